nios_system_jtag_debug_ocimem_sequencer: RTL
============================================

Name: nios_system_jtag_debug_ocimem_sequencer

Overview:
System-clock-domain sequencer between the JTAG debug module's sysclk action strobes (take_action_ocimem_a/b, take_no_action_ocimem_a, jdo) and the on-chip debug memory (debug ROM/RAM) port. It turns one-cycle debugger commands into single-word read/write transactions with req/ack handshakes. It maintains the auto-incrementing monitor address and returns read data in MonDReg for the next JTAG scan. It also flags dropped commands and stalled accesses so host software can detect them.

Parameters:
ADDR_W, 8, word-address width of debug memory (256 words)
DATA_W, 32, data width; fixed at 32 in this revision
TIMEOUT, 64, cycles to wait for mem_ack before aborting an access (must be >= 2)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
take_action_ocimem_a  in  1  one-cycle pulse: load address from jdo, then read
take_no_action_ocimem_a  in  1  one-cycle pulse: read at current address, then increment
take_action_ocimem_b  in  1  one-cycle pulse: write jdo data at current address, then increment
jdo  in  38  JTAG data word, sampled only on a command pulse
mem_ack  in  1  memory completion; read data valid in the same cycle
mem_rdata  in  32  memory read data
mem_req  out  1  access request, held until ack or timeout
mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
mem_addr  out  ADDR_W  word address; valid while mem_req is high
mem_wdata  out  32  write data
MonDReg  out  32  last read data, or the abort pattern
mon_addr  out  ADDR_W  current monitor address
busy  out  1  high whenever state is not IDLE
overrun_err  out  1  sticky: a command arrived while busy
timeout_err  out  1  sticky: an access timed out

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on reset_n. All state changes occur on the rising edge of clk.
- Reset values: every output is 0; the state is IDLE; the timeout counter is 0. If reset is asserted mid-access, mem_req drops on the next edge and no partial update occurs.
- State machine: IDLE, RD, WR.
- Command priority when pulses coincide: b > a > no_action. Lower-priority pulses in the same cycle are ignored and do not set overrun_err.
- IDLE + take_action_ocimem_a:
  - mon_addr <= jdo[17+ADDR_W-1:17]; mem_addr <= the same value.
  - mem_we <= 0; mem_req <= 1; go to RD with the inc flag = 0.
- IDLE + take_no_action_ocimem_a: mem_addr <= mon_addr; mem_we <= 0; mem_req <= 1; go to RD with inc = 1.
- IDLE + take_action_ocimem_b: mem_addr <= mon_addr; mem_wdata <= jdo[34:3]; mem_we <= 1; mem_req <= 1; go to WR with inc = 1.
- Latency: a command pulse in cycle N gives mem_req high in cycle N+1.
- RD/WR completion: mem_ack is honoured in any cycle with mem_req high, including the first cycle. On the edge after ack:
  - mem_req <= 0 and the state returns to IDLE.
  - For RD, MonDReg <= mem_rdata.
  - If inc = 1, mon_addr <= mon_addr + 1, wrapping modulo 2^ADDR_W (all-ones goes to 0).
- mem_ack while IDLE is ignored.
- Timeout: the counter is cleared on entry to RD/WR and increments each cycle without ack. When it reaches TIMEOUT-1 without ack:
  - mem_req <= 0; timeout_err <= 1; the state returns to IDLE.
  - For RD, MonDReg <= 32'hDEAD_DEAD.
  - mon_addr is not incremented.
- Any command pulse while busy is dropped and sets overrun_err <= 1.
- overrun_err and timeout_err clear only on an accepted take_action_ocimem_a or on reset. If that same command also times out, timeout_err is set again.
- busy is registered and equals (state != IDLE). A new command is accepted in the cycle after busy falls.
- mem_addr, mem_we and mem_wdata hold their values after the request ends.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with pulses applied -> all outputs 0, no mem_req.
- Address load and read: take_action_ocimem_a with jdo[24:17]=8'h40; ack in the 2nd request cycle with rdata=32'h1234_5678 -> mem_req from N+1 to N+2, mem_addr=8'h40, MonDReg=32'h1234_5678, mon_addr stays 8'h40.
- Write with wrap: mon_addr=8'hFF, take_action_ocimem_b with jdo[34:3]=32'hCAFE_F00D, ack on the first cycle -> one write to 8'hFF with that data, mon_addr becomes 8'h00.
- Timeout: take_no_action_ocimem_a with ack never asserted -> mem_req high for exactly 64 cycles, timeout_err=1, MonDReg=32'hDEAD_DEAD, mon_addr unchanged.
- Overrun and priority: during a busy read, pulse take_action_ocimem_b -> overrun_err=1 and no second request. Then pulse a and b together in IDLE -> a write occurs and overrun_err stays 1. A later take_action_ocimem_a clears it.
- Reset mid-write: assert reset_n=0 while in WR -> mem_req=0 on the next edge and mon_addr=0.

Source files
------------

// File: rtl/nios_system_jtag_debug_ocimem_sequencer.sv
// Turns one-cycle JTAG debug strobes into single-word debug-memory accesses.
// Latency: request one cycle after the strobe; done the edge after ack or after TIMEOUT request cycles.
// Backpressure: strobes arriving while busy are dropped and flagged in overrun_err.
module nios_system_jtag_debug_ocimem_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic [ADDR_W-1:0] mon_addr,
    output logic              busy,
    output logic              overrun_err,
    output logic              timeout_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ABORT_PAT = DATA_W'(32'hDEAD_DEAD);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t          state;
    logic            inc;
    logic [CW-1:0]   tcnt;
    logic            any_cmd;
    logic            unused_jdo;

    assign any_cmd    = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign unused_jdo = &{1'b0, jdo};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            inc         <= 1'b0;
            tcnt        <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            MonDReg     <= '0;
            mon_addr    <= '0;
            busy        <= 1'b0;
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    // b outranks a outranks no_action; losers are silently ignored
                    if (take_action_ocimem_b) begin
                        mem_addr  <= mon_addr;
                        mem_wdata <= jdo[34:3];
                        mem_we    <= 1'b1;
                        mem_req   <= 1'b1;
                        inc       <= 1'b1;
                        busy      <= 1'b1;
                        state     <= WR;
                    end else if (take_action_ocimem_a) begin
                        mon_addr    <= jdo[17+ADDR_W-1:17];
                        mem_addr    <= jdo[17+ADDR_W-1:17];
                        mem_we      <= 1'b0;
                        mem_req     <= 1'b1;
                        inc         <= 1'b0;
                        busy        <= 1'b1;
                        overrun_err <= 1'b0;
                        timeout_err <= 1'b0;
                        state       <= RD;
                    end else if (take_no_action_ocimem_a) begin
                        mem_addr <= mon_addr;
                        mem_we   <= 1'b0;
                        mem_req  <= 1'b1;
                        inc      <= 1'b1;
                        busy     <= 1'b1;
                        state    <= RD;
                    end
                end
                default: begin
                    if (any_cmd)
                        overrun_err <= 1'b1;
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                        if (state == RD)
                            MonDReg <= mem_rdata;
                        if (inc)
                            mon_addr <= mon_addr + ADDR_W'(1);
                    end else if (tcnt == TMAX) begin
                        // abandoned access: address stays put so the host can retry
                        mem_req     <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                        if (state == RD)
                            MonDReg <= ABORT_PAT;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule
